// File: rtl/misr_pkg.sv
// Shared types and the MISR next-state function for the signature checker.
// Imported by misr_core and misr_sig_checker.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest signature the step function handles.
  localparam int unsigned MAXW = 64;

  // One compaction step: right shift, parity of tapped bits into the MSB,
  // then XOR in the (already zero-extended) observation word.
  function automatic logic [MAXW-1:0] misr_step(
    input logic [MAXW-1:0] sig,
    input logic [MAXW-1:0] d,
    input logic [MAXW-1:0] poly,
    input int unsigned     w
  );
    logic            fb;
    logic [MAXW-1:0] top;
    fb  = ^(sig & poly);
    top = MAXW'(fb) << (w - 1);
    return ((sig >> 1) | top) ^ d;
  endfunction

endpackage

// File: rtl/misr_core.sv
// MISR signature register: loads SEED, or steps with a WIDTH-bit data word.
// Ports: clk, rst, load_i, step_i, d_i[WIDTH], sig_o[WIDTH].
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    unique case (1'b1)
      load_i: sig_d = SEED;
      step_i: sig_d = WIDTH'(misr_step(MAXW'(sig_q), MAXW'(d_i),
                                       MAXW'(POLY), WIDTH));
      default: sig_d = sig_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= SEED;
    else     sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/misr_sig_checker.sv
// MISR window compactor with golden compare and one-shot fault injection.
// Ports: clk, rst, start, abort, window_len, golden, inj_arm, inj_beat,
//   inj_mask, din_valid, din -> busy, done, match, mismatch, injected,
//   signature, beat_cnt.
module misr_sig_checker
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH = 4,
  parameter int unsigned      IN_W  = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b1001,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001,
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window_len,
  input  logic [WIDTH-1:0] golden,
  input  logic             inj_arm,
  input  logic [CNT_W-1:0] inj_beat,
  input  logic [IN_W-1:0]  inj_mask,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             mismatch,
  output logic             injected,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] beat_cnt
);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ibeat_q;
  logic [WIDTH-1:0] golden_q;
  logic [IN_W-1:0]  imask_q;
  logic             arm_q;
  logic             inj_q;

  logic             go;
  logic             acc;
  logic             hit;
  logic             last;
  logic [IN_W-1:0]  d;
  logic [WIDTH-1:0] sig;

  // start is only honoured outside RUN; abort wins over start.
  assign go   = start && !abort && (state_q != RUN);
  assign acc  = (state_q == RUN) && din_valid && !abort;
  assign hit  = arm_q && (cnt_q == ibeat_q);
  assign d    = hit ? (din ^ imask_q) : din;
  assign last = (cnt_q + 1'b1) == len_q;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (go),
    .step_i (acc),
    .d_i    (WIDTH'(d)),
    .sig_o  (sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ibeat_q  <= '0;
      golden_q <= '0;
      imask_q  <= '0;
      arm_q    <= 1'b0;
      inj_q    <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= window_len;
            golden_q <= golden;
            arm_q    <= inj_arm;
            ibeat_q  <= inj_beat;
            imask_q  <= inj_mask;
            cnt_q    <= '0;
            inj_q    <= 1'b0;
            state_q  <= (window_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (din_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (hit)  inj_q   <= 1'b1;
            if (last) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign match     = done && (sig == golden_q);
  assign mismatch  = done && (sig != golden_q);
  assign injected  = inj_q;
  assign signature = sig;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// Scoreboard bench for misr_sig_checker: directed spec traces plus random
// windows checked against a parity-feedback shift model.
module tb_misr_sig_checker;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam logic [3:0] POLY = 4'b1001;
  localparam logic [3:0] SEED = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] window_len;
  logic [W-1:0]  golden;
  logic          inj_arm;
  logic [CW-1:0] inj_beat;
  logic [W-1:0]  inj_mask;
  logic          din_valid;
  logic [W-1:0]  din;
  logic          busy, done, match, mismatch, injected;
  logic [W-1:0]  signature;
  logic [CW-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] sig;
    bit         mat;
    bit         inj;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  misr_sig_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .window_len (window_len),
    .golden     (golden),
    .inj_arm    (inj_arm),
    .inj_beat   (inj_beat),
    .inj_mask   (inj_mask),
    .din_valid  (din_valid),
    .din        (din),
    .busy       (busy),
    .done       (done),
    .match      (match),
    .mismatch   (mismatch),
    .injected   (injected),
    .signature  (signature),
    .beat_cnt   (beat_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: shift right, parity of the tapped bits enters at the top.
  function automatic logic [3:0] mstep(input logic [3:0] s,
                                       input logic [3:0] dd);
    int fb;
    fb = $countones(s & POLY) % 2;
    return ((s >> 1) | (fb != 0 ? 4'b1000 : 4'b0000)) ^ dd;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every entry into DONE pops one expected result.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        chk("excl", {31'd0, match ^ mismatch}, 32'd1);
      end else begin
        chk("flags_idle", {30'd0, match, mismatch}, 32'd0);
      end
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_sig", {28'd0, signature}, {28'd0, e.sig});
          chk("sb_match", {31'd0, match}, {31'd0, e.mat});
          chk("sb_mismatch", {31'd0, mismatch}, {31'd0, !e.mat});
          chk("sb_inj", {31'd0, injected}, {31'd0, e.inj});
          chk("sb_cnt", {24'd0, beat_cnt}, e.cnt);
        end
      end
    end
    prev_done = done;
  end

  task automatic run_window(input int len, input logic [3:0] gold,
                            input bit arm, input int ib,
                            input logic [3:0] im, input int gap,
                            input logic [3:0] data_in[$],
                            input logic [3:0] tr[$]);
    logic [3:0] data[$];
    logic [3:0] s;
    logic [3:0] dd;
    bit         inj;
    exp_t       e;
    int         g;
    data = data_in;
    while (data.size() < len) data.push_back(4'($urandom));
    s   = SEED;
    inj = 1'b0;
    for (int k = 0; k < len; k++) begin
      dd = data[k];
      if (arm && k == ib) begin
        dd  = dd ^ im;
        inj = 1'b1;
      end
      s = mstep(s, dd);
    end
    e.sig = s;
    e.mat = (s == gold);
    e.inj = inj;
    e.cnt = len;
    if (len == 0 && done) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    sb.push_back(e);
    start      = 1'b1;
    window_len = CW'(len);
    golden     = gold;
    inj_arm    = arm;
    inj_beat   = CW'(ib);
    inj_mask   = im;
    tick();
    start      = 1'b0;
    window_len = CW'($urandom);
    golden     = 4'($urandom);
    inj_arm    = 1'($urandom);
    inj_beat   = CW'($urandom);
    inj_mask   = 4'($urandom);
    if (len == 0) begin
      chk("len0_done", {31'd0, done}, 32'd1);
    end else begin
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_sig", {28'd0, signature}, {28'd0, SEED});
      chk("start_cnt", {24'd0, beat_cnt}, 32'd0);
    end
    for (int k = 0; k < len; k++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) begin
        din = 4'($urandom);
        tick();
      end
      din_valid = 1'b1;
      din       = data[k];
      tick();
      din_valid = 1'b0;
      if (k < tr.size())
        chk("trace_sig", {28'd0, signature}, {28'd0, tr[k]});
    end
    if (len > 0) chk("done_lat", {30'd0, done, busy}, 32'd2);
  endtask

  initial begin
    logic [3:0] nd[$];
    logic [3:0] d2[$];
    logic [3:0] t2[$];
    logic [3:0] d3[$];
    logic [3:0] t3[$];
    logic [3:0] t4[$];
    nd = {};
    d2 = {4'h0, 4'h0, 4'h0};
    t2 = {4'h8, 4'hC, 4'hE};
    d3 = {4'h3, 4'h5};
    t3 = {4'hB, 4'h0};
    t4 = {4'hB, 4'h1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; window_len = '0;
    golden = '0; inj_arm = 1'b0; inj_beat = '0; inj_mask = '0;
    din_valid = 1'b0; din = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_sig", {28'd0, signature}, {28'd0, SEED});
    chk("rst_flags", {27'd0, busy, done, match, mismatch, injected}, 32'd0);
    chk("rst_cnt", {24'd0, beat_cnt}, 32'd0);

    run_window(3, 4'hE, 1'b0, 0, 4'h0, 0, d2, t2);
    run_window(2, 4'h0, 1'b0, 0, 4'h0, 1, d3, t3);
    run_window(2, 4'h0, 1'b1, 1, 4'h1, 0, d3, t4);
    run_window(2, 4'h0, 1'b1, 3, 4'h1, 0, d3, t3);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_over_start", {30'd0, done, busy}, 32'd0);

    run_window(0, 4'h1, 1'b0, 0, 4'h0, 0, nd, nd);
    run_window(3, 4'hE, 1'b0, 0, 4'h0, 2, d2, t2);

    // abort after the first beat
    start = 1'b1;
    window_len = 8'd4;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    din = 4'($urandom);
    tick();
    din_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {30'd0, done, busy}, 32'd0);

    // reset mid-window
    start = 1'b1;
    window_len = 8'd4;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    din = 4'h6;
    tick();
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rstmid_sig", {28'd0, signature}, {28'd0, SEED});
    chk("rstmid_flags", {27'd0, busy, done, match, mismatch, injected},
        32'd0);
    chk("rstmid_cnt", {24'd0, beat_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // start taken straight from DONE
    run_window(2, 4'h0, 1'b0, 0, 4'h0, 0, d3, t3);
    run_window(3, 4'hE, 1'b0, 0, 4'h0, 0, d2, t2);

    for (int i = 0; i < 30; i++) begin
      run_window($urandom_range(0, 6), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 7), 4'($urandom), -1, nd, nd);
      if ($urandom_range(0, 2) == 0) tick();
    end

    repeat (3) tick();
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
